// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
//   Resynchronises a Gray code that is asynchronous to clk and decodes it to
//   binary. Each code step is reported as a one-cycle pulse with a direction
//   flag. A multi-bit jump between consecutive samples sets a sticky error.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   g        in   WIDTH  Gray code input, async to clk
//   err_clr  in   1      synchronous clear of err (and err_cnt)
//   b        out  WIDTH  registered binary decode of synchronised g
//   chg      out  1      one-cycle pulse: b updated this cycle
//   up       out  1      direction of last legal step (1 = +1, 0 = -1)
//   err      out  1      sticky: multi-bit Gray jump seen
//   err_cnt  out  8      saturating error count (only with GSD_ERR_CNT_EN)
//
// Configuration
//   GSD_ERR_CNT_EN  define to add the err_cnt port and its saturating counter.
module gray_sync_decoder #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g,
    input  logic             err_clr,
    output logic [WIDTH-1:0] b,
    output logic             chg,
    output logic             up,
    output logic             err
`ifdef GSD_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);

    typedef enum logic {INIT, TRACK} state_t;

    // INIT lasts until the synchroniser holds samples taken after reset
    // release; otherwise the zeroed chain would be compared against the
    // real code and raise a false jump when g != 0 at reset exit.
    localparam int unsigned FILL = SYNC_STAGES + 1;
    localparam int unsigned CW   = $clog2(FILL + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] bin_s, bin_p, diff;
    logic [WIDTH-1:0] b_d;
    logic             chg_d, up_d, err_d, illegal;
    logic [CW-1:0]    fill_q, fill_d;
    state_t           state_q, state_d;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] gc);
        logic [WIDTH-1:0] r;
        r = '0;
        r[WIDTH-1] = gc[WIDTH-1];
        for (int unsigned k = 1; k < WIDTH; k++) begin
            r[WIDTH-1-k] = r[WIDTH-k] ^ gc[WIDTH-1-k];
        end
        return r;
    endfunction

    // Synchroniser chain; s is the only view of g used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= g;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s     = sync_q[SYNC_STAGES-1];
    assign bin_s = gray2bin(s);
    assign bin_p = gray2bin(p_q);
    assign diff  = s ^ p_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= INIT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (fill_q == CW'(FILL - 1)) state_d = TRACK;
            TRACK:   state_d = TRACK;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        b_d     = b;
        chg_d   = chg;
        up_d    = up;
        p_d     = p_q;
        fill_d  = fill_q;
        illegal = 1'b0;
        unique case (state_q)
            INIT: begin
                p_d    = s;
                b_d    = bin_s;
                fill_d = fill_q + CW'(1);
            end
            TRACK: begin
                chg_d = 1'b0;
                if (diff != '0) begin
                    b_d   = bin_s;
                    chg_d = 1'b1;
                    p_d   = s;
                    if ($onehot(diff)) up_d = (bin_s == bin_p + WIDTH'(1));
                    else               illegal = 1'b1;
                end
            end
        endcase
        // A jump in the same cycle as err_clr keeps err set.
        if (illegal)      err_d = 1'b1;
        else if (err_clr) err_d = 1'b0;
        else              err_d = err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q    <= '0;
            b      <= '0;
            chg    <= 1'b0;
            up     <= 1'b1;
            err    <= 1'b0;
            fill_q <= '0;
        end else begin
            p_q    <= p_d;
            b      <= b_d;
            chg    <= chg_d;
            up     <= up_d;
            err    <= err_d;
            fill_q <= fill_d;
        end
    end

`ifdef GSD_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (illegal) begin
            if (err_clr)               err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end else if (err_clr) begin
            err_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb_gray_sync_decoder
//   Directed self-checking bench for gray_sync_decoder (WIDTH=4,
//   SYNC_STAGES=2). Expected values are hand-computed; err_cnt checks are
//   compiled in only when GSD_ERR_CNT_EN is defined.
module tb_gray_sync_decoder;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] g;
    logic       err_clr;
    logic [3:0] b;
    logic       chg, up, err;
`ifdef GSD_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    gray_sync_decoder #(.WIDTH(4), .SYNC_STAGES(SS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g       (g),
        .err_clr (err_clr),
        .b       (b),
        .chg     (chg),
        .up      (up),
        .err     (err)
`ifdef GSD_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with g held at gv, release, then let the INIT fill complete.
    task automatic do_reset(input logic [3:0] gv);
        g     = gv;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (SS + 2) tick();
    endtask

    // Drive a new code and advance to the edge where it reaches b.
    task automatic drive_code(input logic [3:0] gv);
        g = gv;
        repeat (SS + 1) tick();
    endtask

    task automatic test_reset();
        g = 4'b0110; err_clr = 1'b0; rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (b !== 4'b0000) begin errors++; $display("FAIL t1_rst_b: b=%b expected 0000", b); end
        checks++; if (up !== 1'b1)   begin errors++; $display("FAIL t1_rst_up: up=%b expected 1", up); end
        checks++; if (chg !== 1'b0)  begin errors++; $display("FAIL t1_rst_chg: chg=%b expected 0", chg); end
        checks++; if (err !== 1'b0)  begin errors++; $display("FAIL t1_rst_err: err=%b expected 0", err); end
`ifdef GSD_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL t1_rst_cnt: err_cnt=%0d expected 0", err_cnt); end
`endif
        rst_n = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            checks++; if (chg !== 1'b0) begin errors++; $display("FAIL t1_chg: cycle %0d chg=%b expected 0", c, chg); end
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL t1_err: cycle %0d err=%b expected 0", c, err); end
        end
        checks++; if (b !== 4'b0100) begin errors++; $display("FAIL t1_b: b=%b expected 0100", b); end
        checks++; if (up !== 1'b1)   begin errors++; $display("FAIL t1_up: up=%b expected 1", up); end
    endtask

    task automatic test_ascending();
        int pulses = 0;
        do_reset(4'b0000);
        for (int i = 1; i < 16; i++) begin
            g = 4'(i ^ (i >> 1));
            for (int t = 1; t <= 4; t++) begin
                tick();
                if (chg === 1'b1) pulses++;
                checks++;
                if (chg !== (t == 3)) begin
                    errors++; $display("FAIL t2_chg: code %0d cycle %0d chg=%b expected %b", i, t, chg, t == 3);
                end
                checks++;
                if (b !== 4'((t >= 3) ? i : i - 1)) begin
                    errors++; $display("FAIL t2_b: code %0d cycle %0d b=%0d expected %0d", i, t, b, (t >= 3) ? i : i - 1);
                end
                if (t == 3) begin
                    checks++; if (up !== 1'b1) begin errors++; $display("FAIL t2_up: code %0d up=%b expected 1", i, up); end
                end
            end
        end
        checks++; if (pulses != 15) begin errors++; $display("FAIL t2_pulses: pulses=%0d expected 15", pulses); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t2_err: err=%b expected 0", err); end
    endtask

    task automatic test_wrap_reverse();
        drive_code(4'b0000);
        checks++; if (b !== 4'd0 || chg !== 1'b1 || up !== 1'b1) begin
            errors++; $display("FAIL t3_wrap_up: b=%0d chg=%b up=%b expected b=0 chg=1 up=1", b, chg, up);
        end
        tick();
        drive_code(4'b1000);
        checks++; if (b !== 4'd15 || chg !== 1'b1 || up !== 1'b0) begin
            errors++; $display("FAIL t3_wrap_down: b=%0d chg=%b up=%b expected b=15 chg=1 up=0", b, chg, up);
        end
        tick();
        drive_code(4'b1001);
        checks++; if (b !== 4'd14 || chg !== 1'b1 || up !== 1'b0) begin
            errors++; $display("FAIL t3_down: b=%0d chg=%b up=%b expected b=14 chg=1 up=0", b, chg, up);
        end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t3_err: err=%b expected 0", err); end
    endtask

    task automatic test_illegal_jump();
        do_reset(4'b0001);
        drive_code(4'b0000);
        checks++; if (b !== 4'd0 || up !== 1'b0) begin
            errors++; $display("FAIL t4_setup: b=%0d up=%b expected b=0 up=0", b, up);
        end
        tick();
        drive_code(4'b0011);
        checks++; if (b !== 4'b0010) begin errors++; $display("FAIL t4_b: b=%b expected 0010", b); end
        checks++; if (chg !== 1'b1)  begin errors++; $display("FAIL t4_chg: chg=%b expected 1", chg); end
        checks++; if (err !== 1'b1)  begin errors++; $display("FAIL t4_err: err=%b expected 1", err); end
        checks++; if (up !== 1'b0)   begin errors++; $display("FAIL t4_up: up=%b expected 0 (unchanged)", up); end
`ifdef GSD_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL t4_cnt: err_cnt=%0d expected 1", err_cnt); end
`endif
        tick();
    endtask

    task automatic test_err_clr();
        g = 4'b0101;
        repeat (SS) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (b !== 4'b0110) begin errors++; $display("FAIL t5_b: b=%b expected 0110", b); end
        checks++; if (err !== 1'b1)  begin errors++; $display("FAIL t5_set_wins: err=%b expected 1", err); end
`ifdef GSD_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL t5_cnt_load: err_cnt=%0d expected 1", err_cnt); end
`endif
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_clr: err=%b expected 0", err); end
`ifdef GSD_ERR_CNT_EN
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL t5_cnt_clr: err_cnt=%0d expected 0", err_cnt); end
`endif
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t5_stay: err=%b expected 0", err); end
    endtask

    task automatic test_async_reset();
        drive_code(4'b0111);
        checks++; if (b !== 4'd5 || up !== 1'b0 || chg !== 1'b1) begin
            errors++; $display("FAIL t6_setup: b=%0d up=%b chg=%b expected b=5 up=0 chg=1", b, up, chg);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (b !== 4'd0 || chg !== 1'b0 || up !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL t6_async: b=%0d chg=%b up=%b err=%b expected 0 0 1 0", b, chg, up, err);
        end
        #1 rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++; if (chg !== 1'b0 || err !== 1'b0) begin
                errors++; $display("FAIL t6_resume: cycle %0d chg=%b err=%b expected 0 0", c, chg, err);
            end
        end
        checks++; if (b !== 4'b0101) begin errors++; $display("FAIL t6_b: b=%b expected 0101", b); end
    endtask

    task automatic test_back_to_back();
        do_reset(4'b0000);
        for (int c = 1; c <= 8; c++) begin
            if (c <= 5) g = 4'(c ^ (c >> 1));
            tick();
            if (c >= 3 && c <= 7) begin
                checks++; if (chg !== 1'b1 || b !== 4'(c - 2) || up !== 1'b1) begin
                    errors++; $display("FAIL b2b_step: cycle %0d chg=%b b=%0d up=%b expected 1 %0d 1", c, chg, b, up, c - 2);
                end
            end else begin
                checks++; if (chg !== 1'b0 || b !== ((c < 3) ? 4'd0 : 4'd5)) begin
                    errors++; $display("FAIL b2b_idle: cycle %0d chg=%b b=%0d expected 0 %0d", c, chg, b, (c < 3) ? 0 : 5);
                end
            end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL b2b_err: err=%b expected 0", err); end
    endtask

    initial begin
        rst_n   = 1'b0;
        g       = 4'b0000;
        err_clr = 1'b0;
        test_reset();
        test_ascending();
        test_wrap_reverse();
        test_illegal_jump();
        test_err_clr();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
